// File: rtl/simple_cnn.sv
// simple_cnn: single-image CNN inference engine with hard-wired ROM contents.
//   6x6 image -> 8 parallel 3x3 valid convolutions (ReLU at store) ->
//   2x2 max-pool -> 32->10 fully-connected layer -> argmax.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset, priority over enable
//   enable         run qualifier; every busy state stalls while low
//   result[3:0]    argmax class index (ties go to the lowest index)
//   count[15:0]    enabled processing edges consumed (54 at completion)
//   prob_0..prob_9 signed 113-bit FC class scores (running sums during FC)
//   fc_done        high from the edge that enters DONE until reset
module simple_cnn (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [3:0]          result,
  output logic [15:0]         count,
  output logic signed [112:0] prob_0,
  output logic signed [112:0] prob_1,
  output logic signed [112:0] prob_2,
  output logic signed [112:0] prob_3,
  output logic signed [112:0] prob_4,
  output logic signed [112:0] prob_5,
  output logic signed [112:0] prob_6,
  output logic signed [112:0] prob_7,
  output logic signed [112:0] prob_8,
  output logic signed [112:0] prob_9,
  output logic                fc_done
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned CONV_W    = 69;
  localparam int unsigned FC_PROD_W = 101;
  localparam int unsigned ACC_W     = 113;
  localparam int unsigned N_FILT    = 8;
  localparam int unsigned N_POS     = 16;
  localparam int unsigned N_FEAT    = 32;
  localparam int unsigned N_CLASS   = 10;

  typedef enum logic [2:0] {IDLE, CONV, POOL, FC, ARGMAX, DONE} state_t;

  // Image ROM: p(r,c) = 6r + c
  function automatic logic signed [DATA_W-1:0] pix(input int r, input int c);
    return DATA_W'(6 * r + c);
  endfunction

  // Conv kernel ROM: w_k(i,j) = 3i + j - k
  function automatic logic signed [DATA_W-1:0] kw(input int k, input int i, input int j);
    return DATA_W'(3 * i + j - k);
  endfunction

  // FC weight ROM: class n picks every feature with f mod 10 == n
  function automatic logic signed [DATA_W-1:0] fc_w(input int n, input int f);
    return ((f % 10) == n) ? 32'sd1 : 32'sd0;
  endfunction

  state_t                    state_q, state_d;
  logic [4:0]                idx_q, idx_d;
  logic [15:0]               count_q, count_d;
  logic [3:0]                result_q, result_d;
  logic                      fc_done_q, fc_done_d;
  logic signed [CONV_W-1:0]  conv_q [N_FILT][N_POS];
  logic signed [CONV_W-1:0]  conv_d [N_FILT][N_POS];
  logic signed [CONV_W-1:0]  feat_q [N_FEAT];
  logic signed [CONV_W-1:0]  feat_d [N_FEAT];
  logic signed [ACC_W-1:0]   prob_q [N_CLASS];
  logic signed [ACC_W-1:0]   prob_d [N_CLASS];

  logic signed [CONV_W-1:0]  conv_val [N_FILT];
  logic signed [CONV_W-1:0]  pool_val [N_FILT];
  logic signed [ACC_W-1:0]   fc_sum   [N_CLASS];
  logic [3:0]                best_idx;

  // Conv at spatial position idx_q[3:0] (row = [3:2], col = [1:0]), all filters, ReLU applied
  always_comb begin : conv_calc
    logic signed [PROD_W-1:0] prod;
    logic signed [CONV_W-1:0] acc;
    int r0;
    int c0;
    r0   = int'(idx_q[3:2]);
    c0   = int'(idx_q[1:0]);
    prod = '0;
    acc  = '0;
    for (int k = 0; k < int'(N_FILT); k++) begin
      acc = '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          prod = PROD_W'(pix(r0 + i, c0 + j)) * PROD_W'(kw(k, i, j));
          acc  = acc + CONV_W'(prod);
        end
      end
      conv_val[k] = acc[CONV_W-1] ? '0 : acc;
    end
  end

  // Max over 2x2 window idx_q[1:0] = {pr, pc}; positions are {row, col} with row/col = {p, d}
  always_comb begin : pool_calc
    logic [3:0] p00, p01, p10, p11;
    logic signed [CONV_W-1:0] m;
    p00 = {idx_q[1], 1'b0, idx_q[0], 1'b0};
    p01 = {idx_q[1], 1'b0, idx_q[0], 1'b1};
    p10 = {idx_q[1], 1'b1, idx_q[0], 1'b0};
    p11 = {idx_q[1], 1'b1, idx_q[0], 1'b1};
    m   = '0;
    for (int k = 0; k < int'(N_FILT); k++) begin
      m = conv_q[k][p00];
      if (conv_q[k][p01] > m) m = conv_q[k][p01];
      if (conv_q[k][p10] > m) m = conv_q[k][p10];
      if (conv_q[k][p11] > m) m = conv_q[k][p11];
      pool_val[k] = m;
    end
  end

  // One feature (idx_q) multiplied into all ten class accumulators
  always_comb begin : fc_calc
    logic signed [FC_PROD_W-1:0] prod;
    prod = '0;
    for (int n = 0; n < int'(N_CLASS); n++) begin
      prod      = FC_PROD_W'(feat_q[idx_q]) * FC_PROD_W'(fc_w(n, int'(idx_q)));
      fc_sum[n] = prob_q[n] + ACC_W'(prod);
    end
  end

  // Strict greater-than keeps the lowest index on ties
  always_comb begin : argmax_calc
    logic signed [ACC_W-1:0] best_val;
    best_val = prob_q[0];
    best_idx = '0;
    for (int n = 1; n < int'(N_CLASS); n++) begin
      if (prob_q[n] > best_val) begin
        best_val = prob_q[n];
        best_idx = 4'(n);
      end
    end
  end

  // Next-state and datapath update; nothing moves while enable is low
  always_comb begin : next_state
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    result_d  = result_q;
    fc_done_d = fc_done_q;
    conv_d    = conv_q;
    feat_d    = feat_q;
    prob_d    = prob_q;
    if (enable && (state_q != DONE)) begin
      count_d = count_q + 16'd1;
    end
    if (enable) begin
      case (state_q)
        IDLE: begin
          state_d = CONV;
          idx_d   = '0;
        end
        CONV: begin
          for (int k = 0; k < int'(N_FILT); k++) begin
            conv_d[k][idx_q[3:0]] = conv_val[k];
          end
          if (idx_q[3:0] == 4'd15) begin
            state_d = POOL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        POOL: begin
          // Feature index f = 4k + 2*pr + pc
          for (int k = 0; k < int'(N_FILT); k++) begin
            feat_d[{3'(k), idx_q[1:0]}] = pool_val[k];
          end
          if (idx_q[1:0] == 2'd3) begin
            state_d = FC;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        FC: begin
          prob_d = fc_sum;
          if (idx_q == 5'd31) begin
            state_d = ARGMAX;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        ARGMAX: begin
          result_d  = best_idx;
          fc_done_d = 1'b1;
          state_d   = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset clearing every buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      fc_done_q <= 1'b0;
      for (int k = 0; k < int'(N_FILT); k++) begin
        for (int p = 0; p < int'(N_POS); p++) begin
          conv_q[k][p] <= '0;
        end
      end
      for (int f = 0; f < int'(N_FEAT); f++) begin
        feat_q[f] <= '0;
      end
      for (int n = 0; n < int'(N_CLASS); n++) begin
        prob_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      result_q  <= result_d;
      fc_done_q <= fc_done_d;
      conv_q    <= conv_d;
      feat_q    <= feat_d;
      prob_q    <= prob_d;
    end
  end

  assign result  = result_q;
  assign count   = count_q;
  assign fc_done = fc_done_q;
  assign prob_0  = prob_q[0];
  assign prob_1  = prob_q[1];
  assign prob_2  = prob_q[2];
  assign prob_3  = prob_q[3];
  assign prob_4  = prob_q[4];
  assign prob_5  = prob_q[5];
  assign prob_6  = prob_q[6];
  assign prob_7  = prob_q[7];
  assign prob_8  = prob_q[8];
  assign prob_9  = prob_q[9];

endmodule

// File: tb/tb_simple_cnn.sv
// tb_simple_cnn: directed self-checking bench for simple_cnn.
module tb_simple_cnn;

  logic                clk;
  logic                rst;
  logic                enable;
  logic [3:0]          result;
  logic [15:0]         count;
  logic signed [112:0] prob [10];
  logic                fc_done;

  int checks;
  int errors;

  // Hand-derived final class scores and selected pooled features
  localparam int EXP_PROB [10] = '{1251, 1341, 1290, 1380, 840, 912, 930, 984, 480, 516};
  localparam int EXP_F03  [4]  = '{618, 690, 1050, 1122};

  simple_cnn dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .result  (result),
    .count   (count),
    .prob_0  (prob[0]),
    .prob_1  (prob[1]),
    .prob_2  (prob[2]),
    .prob_3  (prob[3]),
    .prob_4  (prob[4]),
    .prob_5  (prob[5]),
    .prob_6  (prob[6]),
    .prob_7  (prob[7]),
    .prob_8  (prob[8]),
    .prob_9  (prob[9]),
    .fc_done (fc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_final(input string tag);
    for (int n = 0; n < 10; n++) begin
      chk($sformatf("%s prob_%0d", tag, n), 128'(prob[n]), 128'(EXP_PROB[n]));
    end
    chk({tag, " result"}, 128'(result), 128'd3);
    chk({tag, " fc_done"}, 128'(fc_done), 128'd1);
    chk({tag, " count"}, 128'(count), 128'd54);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    enable = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state
    chk("rst count", 128'(count), 128'd0);
    chk("rst fc_done", 128'(fc_done), 128'd0);
    chk("rst result", 128'(result), 128'd0);
    chk("rst prob_0", 128'(prob[0]), 128'd0);

    // Idle with enable low for 20 edges
    tick(20);
    chk("idle count", 128'(count), 128'd0);
    chk("idle fc_done", 128'(fc_done), 128'd0);
    chk("idle result", 128'(result), 128'd0);
    chk("idle prob_3", 128'(prob[3]), 128'd0);

    // Full run with enable held high
    enable = 1'b1;
    tick(53);
    chk("run1 count@53", 128'(count), 128'd53);
    chk("run1 fc_done@53", 128'(fc_done), 128'd0);
    tick(1);
    chk_final("run1");
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("run1 feat_%0d", f), 128'(dut.feat_q[f]), 128'(EXP_F03[f]));
    end
    for (int f = 16; f < 20; f++) begin
      chk($sformatf("run1 feat_%0d", f), 128'(dut.feat_q[f]), 128'd114);
    end
    chk("run1 feat_20", 128'(dut.feat_q[20]), 128'd51);
    chk("run1 feat_21", 128'(dut.feat_q[21]), 128'd33);
    for (int f = 22; f < 32; f++) begin
      chk($sformatf("run1 feat_%0d", f), 128'(dut.feat_q[f]), 128'd0);
    end
    tick(5);
    chk("run1 hold count", 128'(count), 128'd54);
    chk("run1 hold fc_done", 128'(fc_done), 128'd1);
    chk("run1 hold prob_3", 128'(prob[3]), 128'd1380);

    // Reset out of DONE clears outputs and buffers
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    enable = 1'b0;
    chk("rst2 count", 128'(count), 128'd0);
    chk("rst2 fc_done", 128'(fc_done), 128'd0);
    chk("rst2 result", 128'(result), 128'd0);
    chk("rst2 prob_3", 128'(prob[3]), 128'd0);
    chk("rst2 feat_0", 128'(dut.feat_q[0]), 128'd0);

    // Stall mid-FC: after 30 edges features 0..8 are accumulated (prob_n = f_n)
    enable = 1'b1;
    tick(30);
    chk("stall pre count", 128'(count), 128'd30);
    chk("stall pre prob_0", 128'(prob[0]), 128'd618);
    chk("stall pre prob_8", 128'(prob[8]), 128'd366);
    chk("stall pre prob_9", 128'(prob[9]), 128'd0);
    enable = 1'b0;
    tick(10);
    chk("stall count", 128'(count), 128'd30);
    chk("stall prob_0", 128'(prob[0]), 128'd618);
    chk("stall prob_8", 128'(prob[8]), 128'd366);
    chk("stall prob_9", 128'(prob[9]), 128'd0);
    chk("stall fc_done", 128'(fc_done), 128'd0);
    enable = 1'b1;
    tick(23);
    chk("stall count@53", 128'(count), 128'd53);
    chk("stall fc_done@53", 128'(fc_done), 128'd0);
    tick(1);
    chk_final("stall");

    // Reset mid-CONV with enable high, then a clean rerun
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("conv count", 128'(count), 128'd10);
    rst = 1'b1;
    tick(1);
    chk("midrst count", 128'(count), 128'd0);
    chk("midrst fc_done", 128'(fc_done), 128'd0);
    chk("midrst result", 128'(result), 128'd0);
    chk("midrst prob_0", 128'(prob[0]), 128'd0);
    rst = 1'b0;
    tick(53);
    chk("rerun fc_done@53", 128'(fc_done), 128'd0);
    tick(1);
    chk_final("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_cnn.md
Name: simple_cnn

Overview:
- Self-contained single-image CNN inference engine.
- Fixed pipeline: 6x6 image, 8 parallel 3x3 convolutions, ReLU, 2x2 max-pool, 32->10 fully-connected layer, argmax.
- Image and all weights are hard-wired ROM contents, defined below.
- Top-level leaf block: exposes class scores, the winning class, a progress counter and a done flag.

Parameters:
- None. Geometry, widths and ROM contents are fixed.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run qualifier; processing advances only on edges where enable=1.
- result  output  4  argmax class index 0..9.
- count  output  16  number of enabled processing edges consumed.
- prob_0..prob_9  output  113 each, signed  FC class scores.
- fc_done  output  1  high once result and scores are final.

Behaviour:
- ROM contents, all values signed 32-bit:
  - Pixel p(r,c) = 6r+c, for r,c in 0..5.
  - Kernel k (0..7) weight w_k(i,j) = 3i+j-k; conv bias 0.
  - FC weight W_n(f) = 1 if f mod 10 == n, else 0; FC bias 0.
- Conv (valid, stride 1), 4x4 outputs per filter:
  - conv_k(r,c) = sum over i,j of p(r+i,c+j)*w_k(i,j).
  - 64-bit products; sum sign-extended to 69 bits.
- ReLU: negative values become 0; width stays 69 bits.
- Pool: 2x2 non-overlapping max, giving 2x2 per filter. Feature index f = 4k + 2*pr + pc (0..31).
- FC: prob_n = sum over f of feature_f*W_n(f).
  - Products are 101 bits, accumulated in 113-bit signed registers; no overflow is possible.
- Argmax: result = index of the largest prob; ties go to the lowest index.
- FSM states: IDLE, CONV, POOL, FC, ARGMAX, DONE.
  - IDLE -> CONV on an edge with enable=1; count becomes 1.
  - CONV: 16 enabled edges, one spatial position per edge, all 8 filters in parallel; ReLU applied at store.
  - POOL: 4 enabled edges, one window per edge, 8 filters in parallel.
  - FC: 32 enabled edges, one feature per edge, all 10 accumulators in parallel.
  - ARGMAX: 1 edge; result registered.
  - DONE: terminal; leaves only via rst.
- count increments on every enabled edge outside IDLE/DONE, including the start edge. It equals 54 on entry to DONE and holds there.
- fc_done is registered and goes high on the same edge that enters DONE (54th enabled edge); it stays high until rst.
- enable=0 in any busy state: full stall. State, count, accumulators and intermediate buffers all hold.
- rst=1 on any edge, including mid-operation or with enable=1:
  - state=IDLE, count=0, all prob_n=0, result=0, fc_done=0, intermediate buffers cleared.
  - rst has priority over enable.
- prob_n reflect the running accumulators during FC; they are final only when fc_done=1.
- Outputs are never X after reset, whatever enable does.

Test Plan:
- Reset, then enable held high -> fc_done rises exactly 54 edges after the first enabled edge; count=54 and holds.
- Same run, check final scores -> prob_0..prob_9 = 1251, 1341, 1290, 1380, 840, 912, 930, 984, 480, 516; result=3.
- Check internal features in the same run:
  - f0..f3 = 618, 690, 1050, 1122.
  - f16..f19 = 114.
  - f20 = 51, f21 = 33.
  - f22..f31 = 0 (exercises ReLU clipping of filters 5-7).
- Drop enable low for 10 edges mid-FC -> count and prob values frozen; fc_done arrives 10 edges later; final values unchanged.
- Assert rst for one edge mid-CONV with enable high -> all outputs 0 next edge; a rerun reproduces the identical 54-edge result.
- Hold enable=0 after reset for 20 edges -> state stays IDLE, count=0, fc_done=0, result=0.
